note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a loaded song by stepping through the 100-beat red/yellow/blue note maps produced by the song loader at a fixed tempo. It presents the current beat and an 8-beat look-ahead window per colour to the display and hit-judging logic, and tracks song progress. It sits between the song loader and the game/render logic, and it owns the start, pause, stop and done sequencing.

## Interface
- TICKS_PER_BEAT, 12_500_000: clock cycles each beat is presented (≥1; 4 beats/s at 50 MHz).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to 0.
- start  in  1  level, sampled per cycle; begins a song from IDLE or DONE.
- pause  in  1  level; freezes beat timing while high.
- stop  in  1  level; synchronous abort to IDLE, priority over start and pause.
- map_red, map_yellow, map_blue  in  100 each  note maps; bit k = note on beat k.
- total_notes  in  8  loader's note count, latched at LOAD.
- win_red, win_yellow, win_blue  out  8 each  bit i = note on beat (beat_index+i); bit 0 = current beat.
- beat_index  out  7  current beat, 0..99.
- beat_pulse  out  1  high for the first cycle each beat is presented, including beat 0.
- notes_emitted  out  8  set bits in all retired beats, saturating at 255.
- count_match  out  1  in DONE: notes_emitted == latched total_notes.
- busy  out  1  state is LOAD, PLAY or PAUSE.
- paused  out  1  state is PAUSE.
- done  out  1  state is DONE.

## Operation
- States: IDLE, LOAD, PLAY, PAUSE, DONE. Reset → IDLE.
- IDLE/DONE + start=1 (stop=0) → LOAD.
- LOAD (1 cycle):
  - Copy the three maps into internal 100-bit shift registers.
  - Latch total_notes.
  - Clear notes_emitted, beat_index and the tick counter.
  - Go to PLAY.
- Map inputs are ignored outside LOAD. A song_select change mid-song has no effect.
- PLAY:
  - The tick counter increments each cycle.
  - At TICKS_PER_BEAT-1 the beat retires:
    - notes_emitted += red[0]+yellow[0]+blue[0] of the shift registers (saturating).
    - If beat_index==99 → DONE.
    - Otherwise shift all registers right by 1 (zero fill at bit 99), beat_index+1, tick=0, assert beat_pulse next cycle.
- PLAY + pause=1 → PAUSE. The tick counter does not advance in that cycle.
- PAUSE:
  - The tick counter holds.
  - pause=0 → PLAY; the counter also holds in that transition cycle.
  - Net effect: a pause pulse N cycles long delays the beat by N+1 cycles.
- stop=1 in any state → IDLE next cycle.
  - Window outputs and beat_index read 0 in IDLE.
  - notes_emitted holds its value until the next LOAD.
- DONE:
  - Windows read 0.
  - beat_index holds at 99.
  - notes_emitted and count_match are stable until the next LOAD or reset.
- Window outputs are the low 8 bits of the shift registers. Beats past 99 therefore read 0.
- Outputs are zero-masked in IDLE and DONE.

## Timing
- start sampled high at cycle t:
  - LOAD at t+1.
  - PLAY with beat 0 presented and beat_pulse=1 at t+2.
- Beat k (no pauses) occupies cycles t+2+k·T .. t+2+(k+1)·T-1, where T=TICKS_PER_BEAT.
- DONE is entered at t+2+100·T. done, count_match and notes_emitted are final from that cycle.
- All outputs are registered. There is no combinational path from input to output.
- start held high: exactly one LOAD. A new song begins only from DONE, via start, never automatically from PLAY.
- Simultaneous stop and start in IDLE → stays IDLE.
- Simultaneous pause and beat retire: pause wins and the retire is deferred.
- Reset asserted mid-song: immediate (asynchronous) return to IDLE with every output 0, including notes_emitted.

## Test plan
- **Reset:** assert reset mid-PLAY → all outputs 0 in the same cycle. After release, busy=0 and beat_index=0.
- **Basic play:**
  - Setup: TICKS_PER_BEAT=4; red=bit0, yellow=bit1, blue=bit99, total_notes=3; start pulse at cycle 0.
  - Expect beat_pulse at cycles 2,6,10,…; win_red[0]=1 for cycles 2–5; win_yellow[0]=1 for cycles 6–9; win_red=8'b00000001 and win_yellow=8'b00000010 at cycle 2.
  - Expect done=1 at cycle 402 with notes_emitted=3 and count_match=1.
- **Pause:** same setup, pause high for 10 cycles starting at cycle 22 (beat 5) → paused=1 cycles 23–32; beat 6 pulse at cycle 37 instead of 26; done at cycle 413.
- **Input isolation and mismatch:** change map_red to all-ones at cycle 50 → outputs identical to the basic-play run. Repeat with total_notes=5 → count_match=0 at done.
- **Stop/restart:** stop at beat 40 → IDLE next cycle, windows 0, notes_emitted retains its partial value. Start again → LOAD clears the count and beat 0 is presented 2 cycles after start.
- **End window:** red all-ones, TICKS_PER_BEAT=1 → win_red=8'b00011111 at beat 95, 8'b00000001 at beat 99; done with notes_emitted=100.

Source files
------------

// File: rtl/note_sequencer.sv
// Steps through three latched 100-beat note maps at a fixed tempo, presenting
// the current beat plus an 8-beat look-ahead window per colour and song progress.
module note_sequencer #(
  parameter int TICKS_PER_BEAT = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic [99:0] map_red,
  input  logic [99:0] map_yellow,
  input  logic [99:0] map_blue,
  input  logic [7:0]  total_notes,
  output logic [7:0]  win_red,
  output logic [7:0]  win_yellow,
  output logic [7:0]  win_blue,
  output logic [6:0]  beat_index,
  output logic        beat_pulse,
  output logic [7:0]  notes_emitted,
  output logic        count_match,
  output logic        busy,
  output logic        paused,
  output logic        done
);

  localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [6:0] LAST_BEAT = 7'd99;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [99:0]        red_q, red_d;
  logic [99:0]        yellow_q, yellow_d;
  logic [99:0]        blue_q, blue_d;
  logic [7:0]         total_q, total_d;
  logic [7:0]         emitted_q, emitted_d;
  logic [6:0]         beat_q, beat_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               pulse_q, pulse_d;
  logic [8:0]         emitted_sum;
  logic               active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      red_q     <= '0;
      yellow_q  <= '0;
      blue_q    <= '0;
      total_q   <= '0;
      emitted_q <= '0;
      beat_q    <= '0;
      tick_q    <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      red_q     <= red_d;
      yellow_q  <= yellow_d;
      blue_q    <= blue_d;
      total_q   <= total_d;
      emitted_q <= emitted_d;
      beat_q    <= beat_d;
      tick_q    <= tick_d;
      pulse_q   <= pulse_d;
    end
  end

  // Notes on the beat being retired, added with saturation at 255.
  assign emitted_sum = {1'b0, emitted_q} + {8'd0, red_q[0]}
                     + {8'd0, yellow_q[0]} + {8'd0, blue_q[0]};

  always_comb begin
    state_d   = state_q;
    red_d     = red_q;
    yellow_d  = yellow_q;
    blue_d    = blue_q;
    total_d   = total_q;
    emitted_d = emitted_q;
    beat_d    = beat_q;
    tick_d    = tick_q;
    pulse_d   = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          red_d     = map_red;
          yellow_d  = map_yellow;
          blue_d    = map_blue;
          total_d   = total_notes;
          emitted_d = '0;
          beat_d    = '0;
          tick_d    = '0;
          pulse_d   = 1'b1;
          state_d   = S_PLAY;
        end
        S_PLAY: begin
          // Pause takes precedence over a retire landing in the same cycle.
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            emitted_d = emitted_sum[8] ? 8'hFF : emitted_sum[7:0];
            if (beat_q == LAST_BEAT) begin
              state_d = S_DONE;
            end else begin
              red_d    = {1'b0, red_q[99:1]};
              yellow_d = {1'b0, yellow_q[99:1]};
              blue_d   = {1'b0, blue_q[99:1]};
              beat_d   = beat_q + 7'd1;
              tick_d   = '0;
              pulse_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_PAUSE: begin
          if (!pause) state_d = S_PLAY;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign active        = (state_q == S_PLAY) || (state_q == S_PAUSE);
  assign win_red       = active ? red_q[7:0] : 8'd0;
  assign win_yellow    = active ? yellow_q[7:0] : 8'd0;
  assign win_blue      = active ? blue_q[7:0] : 8'd0;
  assign beat_index    = (active || state_q == S_DONE) ? beat_q : 7'd0;
  assign beat_pulse    = pulse_q;
  assign notes_emitted = emitted_q;
  assign count_match   = (state_q == S_DONE) && (emitted_q == total_q);
  assign busy          = (state_q == S_LOAD) || active;
  assign paused        = (state_q == S_PAUSE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: songs are issued with their expected beat
// and done events queued up front; a negedge monitor pops and compares them.
module tb_note_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pause;
  logic        stop;
  logic [99:0] map_red;
  logic [99:0] map_yellow;
  logic [99:0] map_blue;
  logic [7:0]  total_notes;
  logic [7:0]  win_red;
  logic [7:0]  win_yellow;
  logic [7:0]  win_blue;
  logic [6:0]  beat_index;
  logic        beat_pulse;
  logic [7:0]  notes_emitted;
  logic        count_match;
  logic        busy;
  logic        paused;
  logic        done;

  always #5 clk = ~clk;

  note_sequencer #(.TICKS_PER_BEAT(T)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .stop(stop),
    .map_red(map_red),
    .map_yellow(map_yellow),
    .map_blue(map_blue),
    .total_notes(total_notes),
    .win_red(win_red),
    .win_yellow(win_yellow),
    .win_blue(win_blue),
    .beat_index(beat_index),
    .beat_pulse(beat_pulse),
    .notes_emitted(notes_emitted),
    .count_match(count_match),
    .busy(busy),
    .paused(paused),
    .done(done)
  );

  typedef struct {
    int         cyc;
    int         beat;
    logic [7:0] wr;
    logic [7:0] wy;
    logic [7:0] wb;
    int         emitted;
  } beat_exp_t;

  typedef struct {
    int cyc;
    int emitted;
    bit match;
  } done_exp_t;

  beat_exp_t exp_beats[$];
  done_exp_t exp_done[$];
  beat_exp_t mon_b;
  done_exp_t mon_d;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   sb_enable = 1'b0;
  logic done_prev = 1'b0;

  // Free-running cycle index; during cycle c (after its rising edge) cyc == c.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] exp_window(input logic [99:0] m, input int k);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = (k + i < 100) ? m[k + i] : 1'b0;
    return w;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Monitor: every beat_pulse and every rising done consumes one queued expectation.
  always @(negedge clk) begin
    if (sb_enable && reset === 1'b0) begin
      if (beat_pulse === 1'b1) begin
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat_pulse: got beat_pulse=1 at cycle %0d, expected none", cyc);
        end else begin
          mon_b = exp_beats.pop_front();
          checkOutput("pulse_cycle", cyc, mon_b.cyc);
          checkOutput("beat_index", beat_index, mon_b.beat);
          checkOutput("win_red", win_red, mon_b.wr);
          checkOutput("win_yellow", win_yellow, mon_b.wy);
          checkOutput("win_blue", win_blue, mon_b.wb);
          checkOutput("emitted_at_beat", notes_emitted, mon_b.emitted);
        end
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          mon_d = exp_done.pop_front();
          checkOutput("done_cycle", cyc, mon_d.cyc);
          checkOutput("final_emitted", notes_emitted, mon_d.emitted);
          checkOutput("count_match", count_match, mon_d.match);
          checkOutput("done_beat_index", beat_index, 99);
          checkOutput("done_win_red", win_red, 0);
        end
      end
    end
    done_prev = done;
  end

  // Plays one song: queues every expected event from the maps, then drives
  // start/pause/stop on schedule. Offsets are relative to the start cycle.
  task automatic applyStimulus(input logic [99:0] r, input logic [99:0] y, input logic [99:0] b,
                               input logic [7:0] tot, input int p_off, input int p_len,
                               input int s_off, input bit corrupt);
    int t, p, s, done_c, acc, partial, end_c;
    int bs[101];
    beat_exp_t be;
    done_exp_t de;

    @(posedge clk);
    #1;
    t = cyc;
    map_red     = r;
    map_yellow  = y;
    map_blue    = b;
    total_notes = tot;
    start       = 1'b1;

    p = (p_off >= 0) ? t + p_off : -1;
    s = (s_off >= 0) ? t + s_off : -1;
    for (int k = 0; k <= 100; k++)
      bs[k] = t + 2 + k * T + ((p >= 0 && t + 2 + k * T > p) ? p_len + 1 : 0);
    done_c  = bs[100];
    acc     = 0;
    partial = 0;
    for (int k = 0; k < 100; k++) begin
      if (s < 0 || bs[k] <= s) begin
        be.cyc     = bs[k];
        be.beat    = k;
        be.wr      = exp_window(r, k);
        be.wy      = exp_window(y, k);
        be.wb      = exp_window(b, k);
        be.emitted = sat255(acc);
        exp_beats.push_back(be);
      end
      acc += int'(r[k]) + int'(y[k]) + int'(b[k]);
      if (s >= 0 && bs[k + 1] - 1 < s) partial = sat255(acc);
    end
    if (s < 0) begin
      de.cyc     = done_c;
      de.emitted = sat255(acc);
      de.match   = (sat255(acc) == int'(tot));
      exp_done.push_back(de);
    end

    @(posedge clk);
    #1;
    start = 1'b0;
    end_c = (s >= 0) ? s + 2 : done_c + 2;
    while (cyc < end_c) begin
      pause = (p >= 0 && cyc >= p && cyc < p + p_len);
      stop  = (cyc == s);
      if (corrupt && cyc == t + 50) map_red = '1;
      @(negedge clk);
      if (p >= 0 && cyc == p + 1) checkOutput("paused_entered", paused, 1);
      if (p >= 0 && cyc == p + p_len + 1) checkOutput("paused_left", paused, 0);
      if (s >= 0 && cyc == s + 1) begin
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_win_red", win_red, 0);
        checkOutput("stop_win_blue", win_blue, 0);
        checkOutput("stop_beat_index", beat_index, 0);
        checkOutput("stop_partial_emitted", notes_emitted, partial);
        checkOutput("stop_done", done, 0);
      end
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
    stop  = 1'b0;
    checkOutput("beats_outstanding", exp_beats.size(), 0);
    checkOutput("done_outstanding", exp_done.size(), 0);
    exp_beats.delete();
    exp_done.delete();
  endtask

  function automatic logic [99:0] rand_map(input int density);
    logic [99:0] m;
    for (int i = 0; i < 100; i++) m[i] = ($urandom_range(99, 0) < density);
    return m;
  endfunction

  initial begin
    logic [99:0] r, y, b;
    int          d, cnt, p_off, p_len;
    logic [7:0]  tot;

    reset       = 1'b1;
    start       = 1'b0;
    pause       = 1'b0;
    stop        = 1'b0;
    map_red     = '0;
    map_yellow  = '0;
    map_blue    = '0;
    total_notes = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_beat_index", beat_index, 0);
    checkOutput("reset_emitted", notes_emitted, 0);
    checkOutput("reset_pulse", beat_pulse, 0);
    checkOutput("reset_win_red", win_red, 0);
    reset     = 1'b0;
    sb_enable = 1'b1;

    // Directed song: red on beat 0, yellow on beat 1, blue on beat 99.
    r = 100'd1;
    y = 100'd2;
    b = '0;
    b[99] = 1'b1;
    applyStimulus(r, y, b, 8'd3, -1, 0, -1, 1'b0);
    applyStimulus(r, y, b, 8'd3, -1, 0, -1, 1'b1);
    applyStimulus(r, y, b, 8'd3, 22, 10, -1, 1'b0);
    applyStimulus(r, y, b, 8'd5, -1, 0, -1, 1'b1);

    // Stop in the middle of beat 40, then restart from IDLE.
    r = rand_map(40);
    y = rand_map(40);
    b = rand_map(40);
    applyStimulus(r, y, b, 8'd0, -1, 0, 2 + 40 * T + 1, 1'b0);
    applyStimulus(r, y, b, 8'd0, -1, 0, -1, 1'b0);

    // Every red beat set exercises the tail of the window.
    applyStimulus('1, '0, '0, 8'd100, -1, 0, -1, 1'b0);

    // Random songs, including dense ones that saturate the note count.
    for (int n = 0; n < 4; n++) begin
      d = (n == 3) ? 95 : $urandom_range(100, 0);
      r = rand_map(d);
      y = rand_map(d);
      b = rand_map(d);
      cnt = 0;
      for (int i = 0; i < 100; i++) cnt += int'(r[i]) + int'(y[i]) + int'(b[i]);
      tot = $urandom_range(1, 0) ? 8'(sat255(cnt)) : 8'($urandom_range(255, 0));
      p_off = $urandom_range(1, 0) ? int'($urandom_range(2 + 100 * T - 1, 2)) : -1;
      p_len = $urandom_range(15, 1);
      applyStimulus(r, y, b, tot, p_off, p_len, -1, 1'b0);
    end

    // Asynchronous reset partway through a song.
    sb_enable = 1'b0;
    @(posedge clk);
    #1;
    map_red     = 100'd1;
    map_yellow  = 100'd2;
    map_blue    = '0;
    total_notes = 8'd3;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_emitted", notes_emitted, 2);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_beat_index", beat_index, 0);
    checkOutput("async_reset_emitted", notes_emitted, 0);
    checkOutput("async_reset_win_red", win_red, 0);
    checkOutput("async_reset_win_yellow", win_yellow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_beat_index", beat_index, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
